poly_byte_loader: RTL and testbench
===================================

# poly_byte_loader

Upstream feeder for the polynomial dual-port RAM. It accepts a Kyber ByteEncode12 byte stream over a valid/ready handshake and unpacks each 3-byte group into two 12-bit coefficients. Each coefficient pair is written in a single cycle, one coefficient on each RAM port. One start fills a whole polynomial (2^DEPTH coefficients) before the NTT stage runs.

## Interface
- DEPTH, 8, RAM address width; coefficients per load N = 2^DEPTH, bytes per load = 3N/2 (384 at default)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request to begin a load; honoured only in IDLE
- in_valid  input  1  in_data holds a valid byte
- in_data  input  8  packed coefficient byte, stream order b0,b1,b2,...
- in_ready  output  1  loader accepts a byte this cycle
- we_1  output  1  port-1 write strobe
- we_2  output  1  port-2 write strobe
- addr_1  output  DEPTH  port-1 address (even coefficient index)
- addr_2  output  DEPTH  port-2 address (odd coefficient index)
- din_1  output  16  even coefficient, zero-extended
- din_2  output  16  odd coefficient, zero-extended
- busy  output  1  load in progress
- done  output  1  one-cycle pulse, load complete

## Operation
- States: IDLE, RECV, DONE.
- IDLE: in_ready=0. start=1 moves to RECV and clears the byte phase (0..2) and the pair counter k (DEPTH-1 bits). start in any other state is ignored.
- RECV: in_ready=1. A byte transfers on in_valid && in_ready.
  - Phase 0 latches b0. Phase 1 latches b1. Phase 2 takes b2 and issues the pair write.
  - Phase wraps 2->0.
- Unpack: c0 = {b1[3:0], b0} and c1 = {b2, b1[7:4]}.
  - din_1 = {4'b0, c0'} and din_2 = {4'b0, c1'}, where c' is the coefficient after the configuration rule.
- Pair write: addr_1 = 2k and addr_2 = 2k+1. Then k increments.
- The last byte is phase 2 with k = N/2-1.
  - When it is accepted, in_ready drops in the next cycle and the FSM goes to DONE.
- DONE: lasts one cycle with done=1, then returns to IDLE.
- Addresses never wrap within a load. k resets to 0 at each start.
- in_data is ignored whenever in_ready=0.

## Timing
- Reset values:
  - in_ready, we_1, we_2, busy and done are 0.
  - addr_1, addr_2, din_1 and din_2 are 0.
  - State is IDLE and phase and k are 0.
- start accepted at cycle T: busy=1 and in_ready=1 from T+1.
- Write latency: the phase-2 byte accepted at cycle t gives we_1=we_2=1 for exactly cycle t+1, with addr and din valid in that same cycle.
- All write outputs are registered. we_1 and we_2 are always asserted together.
- A byte may be accepted during a write cycle. At full rate a load takes 3N/2 cycles.
- Bubbles (in_valid=0) stall the phase; there is no timeout.
- Final byte accepted at cycle t:
  - the final write happens at t+1;
  - done=1 at t+1 and busy falls at t+2.
- done is 0 at every other time.
- addr and din hold their last values when we=0.
- Reset mid-load: outputs return to reset values immediately and the partial group is discarded. RAM contents already written are left as they are.

## Configuration
- POLY_MOD_REDUCE_EN defined: each coefficient c ≥ 3329 is replaced by c−3329 (result ≤ 766). This is a combinational reduction ahead of the din registers and adds no extra cycle.
- Undefined: the raw 12-bit value is written, 0..4095.

## Test plan
- Basic unpack: start, then bytes 0x01,0x23,0x45 at full rate.
  - Required: one write cycle with addr_1=0, din_1=0x0301, addr_2=1, din_2=0x0452.
- Full load: 384 bytes with back-to-back valid.
  - Required: exactly 128 write cycles with addresses 0/1 … 254/255.
  - Required: done pulses once, in the same cycle as the final write, and busy is low the next cycle.
- Reduction: group 0xFF,0xFF,0xFF.
  - With macro: din_1=din_2=0x02FE. Without macro: 0x0FFF.
  - Group 0x01,0x0D,0x00 gives din_1=0x0000 with macro and 0x0D01 without.
- Backpressure and bubbles: in_valid toggled randomly.
  - Required: the written data and addresses are identical to the full-rate run.
  - Required: no write occurs while a group is incomplete.
- start while busy: pulse start mid-load.
  - Required: ignored, with k and phase unaffected.
  - Required: after done, a new start reloads from address 0.
- Reset mid-load: assert rst after 100 bytes.
  - Required: all outputs 0 and state IDLE.
  - Required: a new start plus 384 bytes completes normally.

Source files
------------

// File: rtl/poly_byte_loader_if.sv
// Byte-stream and dual-port RAM write bundle for poly_byte_loader.
// master = upstream byte source / RAM side, slave = the loader itself.
interface poly_byte_loader_if #(
    parameter int DEPTH = 8
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             we_1;
    logic             we_2;
    logic [DEPTH-1:0] addr_1;
    logic [DEPTH-1:0] addr_2;
    logic [15:0]      din_1;
    logic [15:0]      din_2;

    modport master (
        output in_valid, in_data,
        input  in_ready, we_1, we_2, addr_1, addr_2, din_1, din_2
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, we_1, we_2, addr_1, addr_2, din_1, din_2
    );
endinterface

// File: rtl/poly_byte_loader.sv
// Unpacks a ByteEncode12 byte stream into 12-bit coefficient pairs for a dual-port RAM.
// Optional macro POLY_MOD_REDUCE_EN: subtract q=3329 from coefficients >= q before writing.
module poly_byte_loader #(
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    poly_byte_loader_if.slave   bus
);
    localparam int DATA_W = 8;
    localparam int COEF_W = 12;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [DEPTH-2:0] K_ONE = {{(DEPTH-2){1'b0}}, 1'b1};

    function automatic logic [COEF_W-1:0] reduce_coef(input logic [COEF_W-1:0] c);
`ifdef POLY_MOD_REDUCE_EN
        if (c >= 12'd3329) return c - 12'd3329;
        else               return c;
`else
        return c;
`endif
    endfunction

    logic [1:0]        state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [DEPTH-2:0]  k_q, k_d;
    logic [DATA_W-1:0] b0_q, b0_d;
    logic [DATA_W-1:0] b1_q, b1_d;
    logic              we_q, we_d;
    logic [DEPTH-1:0]  addr1_q, addr1_d;
    logic [DEPTH-1:0]  addr2_q, addr2_d;
    logic [15:0]       din1_q, din1_d;
    logic [15:0]       din2_q, din2_d;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        k_d     = k_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        we_d    = 1'b0;
        addr1_d = addr1_q;
        addr2_d = addr2_q;
        din1_d  = din1_q;
        din2_d  = din2_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RECV;
                    phase_d = 2'd0;
                    k_d     = '0;
                end
            end
            RECV: begin
                if (bus.in_valid) begin
                    case (phase_q)
                        2'd0: begin
                            b0_d    = bus.in_data;
                            phase_d = 2'd1;
                        end
                        2'd1: begin
                            b1_d    = bus.in_data;
                            phase_d = 2'd2;
                        end
                        default: begin
                            // Third byte completes the group: write both coefficients at once.
                            we_d    = 1'b1;
                            addr1_d = {k_q, 1'b0};
                            addr2_d = {k_q, 1'b1};
                            din1_d  = {4'b0, reduce_coef({b1_q[3:0], b0_q})};
                            din2_d  = {4'b0, reduce_coef({bus.in_data, b1_q[7:4]})};
                            phase_d = 2'd0;
                            k_d     = k_q + K_ONE;
                            if (&k_q) state_d = DONE;
                        end
                    endcase
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
            k_q     <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            we_q    <= 1'b0;
            addr1_q <= '0;
            addr2_q <= '0;
            din1_q  <= '0;
            din2_q  <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            k_q     <= k_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            we_q    <= we_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
            din1_q  <= din1_d;
            din2_q  <= din2_d;
        end
    end

    assign bus.in_ready = (state_q == RECV);
    assign bus.we_1     = we_q;
    assign bus.we_2     = we_q;
    assign bus.addr_1   = addr1_q;
    assign bus.addr_2   = addr2_q;
    assign bus.din_1    = din1_q;
    assign bus.din_2    = din2_q;
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
endmodule

// File: tb/tb_poly_byte_loader.sv
// Directed bench for poly_byte_loader: unpack, full load, reduction, bubbles, start-while-busy, reset.
module tb_poly_byte_loader;
    localparam int DEPTH = 8;
    localparam int NB    = 384;
    localparam int NP    = 128;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    poly_byte_loader_if #(.DEPTH(DEPTH)) bus();

    poly_byte_loader #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  stream [NB];
    logic [15:0] exp1 [NP];
    logic [15:0] exp2 [NP];

    logic [7:0]  ra1 [2048];
    logic [7:0]  ra2 [2048];
    logic [15:0] rd1 [2048];
    logic [15:0] rd2 [2048];
    int wcnt     = 0;
    int dcnt     = 0;
    int pair_err = 0;

    // Write/done recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if ((bus.we_1 || bus.we_2) && wcnt < 2048) begin
            ra1[wcnt] <= bus.addr_1;
            ra2[wcnt] <= bus.addr_2;
            rd1[wcnt] <= bus.din_1;
            rd2[wcnt] <= bus.din_2;
            wcnt      <= wcnt + 1;
        end
        if (done) dcnt <= dcnt + 1;
        if (bus.we_1 !== bus.we_2) pair_err <= pair_err + 1;
    end

    function automatic logic [11:0] red(input logic [11:0] c);
`ifdef POLY_MOD_REDUCE_EN
        return (c >= 12'd3329) ? c - 12'd3329 : c;
`else
        return c;
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("ready_timeout", 64'(bus.in_ready), 64'd1);
        tick();
    endtask

    int base;
    int d0;
    int nb;

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        for (int i = 0; i < NB; i++) stream[i] = 8'((i * 73 + 5) ^ (i >> 3));
        for (int k = 0; k < NP; k++) begin
            exp1[k] = {4'b0, red({stream[3*k+1][3:0], stream[3*k]})};
            exp2[k] = {4'b0, red({stream[3*k+2], stream[3*k+1][7:4]})};
        end
        repeat (2) tick();

        // Reset state
        chk("rst_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_busy_done", 64'({busy, done}), 64'd0);
        chk("rst_we", 64'({bus.we_1, bus.we_2}), 64'd0);
        chk("rst_addr", 64'({bus.addr_1, bus.addr_2}), 64'd0);
        chk("rst_din", 64'({bus.din_1, bus.din_2}), 64'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 64'(bus.in_ready), 64'd0);

        // Basic unpack plus reduction groups, then reset after 100 bytes
        base = wcnt;
        pulse_start();
        chk("start_busy_ready", 64'({busy, bus.in_ready}), 64'b11);
        send(8'h01);
        send(8'h23);
        chk("no_early_we", 64'(bus.we_1), 64'd0);
        send(8'h45);
        chk("basic_we", 64'({bus.we_1, bus.we_2}), 64'b11);
        chk("basic_addr", 64'({bus.addr_1, bus.addr_2}), 64'h0001);
        chk("basic_din1", 64'(bus.din_1), 64'h0301);
        chk("basic_din2", 64'(bus.din_2), 64'h0452);
        send(8'hFF);
        chk("hold_we", 64'(bus.we_1), 64'd0);
        chk("hold_din", 64'(bus.din_1), 64'h0301);
        send(8'hFF);
        send(8'hFF);
        chk("ff_addr", 64'({bus.addr_1, bus.addr_2}), 64'h0203);
`ifdef POLY_MOD_REDUCE_EN
        chk("ff_din", 64'({bus.din_1, bus.din_2}), 64'h02FE02FE);
`else
        chk("ff_din", 64'({bus.din_1, bus.din_2}), 64'h0FFF0FFF);
`endif
        send(8'h01);
        send(8'h0D);
        send(8'h00);
`ifdef POLY_MOD_REDUCE_EN
        chk("q_din1", 64'(bus.din_1), 64'h0000);
`else
        chk("q_din1", 64'(bus.din_1), 64'h0D01);
`endif
        chk("q_din2", 64'(bus.din_2), 64'h0000);
        for (int i = 9; i < 100; i++) send(stream[i]);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_ctrl", 64'({busy, done, bus.in_ready, bus.we_1, bus.we_2}), 64'd0);
        chk("midrst_addr", 64'({bus.addr_1, bus.addr_2}), 64'd0);
        chk("midrst_din", 64'({bus.din_1, bus.din_2}), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("midrst_idle", 64'({busy, bus.in_ready}), 64'd0);
        chk("partial_writes", 64'(wcnt - base), 64'd33);

        // Full-rate load
        base = wcnt;
        d0   = dcnt;
        pulse_start();
        for (int i = 0; i < NB; i++) send(stream[i]);
        bus.in_valid = 1'b0;
        chk("final_we_done", 64'({bus.we_1, done, bus.in_ready}), 64'b110);
        chk("final_addr", 64'({bus.addr_1, bus.addr_2}), 64'hFEFF);
        tick();
        chk("after_done", 64'({busy, done, bus.we_1}), 64'd0);
        chk("after_hold", 64'({bus.addr_1, bus.din_1}), 64'({8'hFE, exp1[NP-1]}));
        chk("full_wcnt", 64'(wcnt - base), 64'd128);
        chk("full_dcnt", 64'(dcnt - d0), 64'd1);
        for (int k = 0; k < NP; k++)
            chk($sformatf("full_w%0d", k),
                64'({ra1[base+k], ra2[base+k], rd1[base+k], rd2[base+k]}),
                64'({8'(2*k), 8'(2*k+1), exp1[k], exp2[k]}));

        // Bubbles plus a start pulse mid-load
        base = wcnt;
        d0   = dcnt;
        pulse_start();
        for (int i = 0; i < NB; i++) begin
            if (i == 150) begin
                bus.in_valid = 1'b0;
                pulse_start();
                chk("busy_start_ignored", 64'({busy, bus.in_ready}), 64'b11);
            end
            if ($urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                nb = int'($urandom_range(1, 3));
                for (int j = 0; j < nb; j++) begin
                    tick();
                    chk("bubble_no_we", 64'(bus.we_1), 64'd0);
                end
            end
            send(stream[i]);
            chk($sformatf("grp_we_%0d", i), 64'(bus.we_1), 64'((i % 3) == 2));
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("bub_wcnt", 64'(wcnt - base), 64'd128);
        chk("bub_dcnt", 64'(dcnt - d0), 64'd1);
        for (int k = 0; k < NP; k++)
            chk($sformatf("bub_w%0d", k),
                64'({ra1[base+k], ra2[base+k], rd1[base+k], rd2[base+k]}),
                64'({8'(2*k), 8'(2*k+1), exp1[k], exp2[k]}));

        // Reload starts at address 0
        pulse_start();
        send(stream[0]);
        send(stream[1]);
        send(stream[2]);
        bus.in_valid = 1'b0;
        chk("reload_addr", 64'({bus.we_1, bus.addr_1, bus.addr_2}), 64'({1'b1, 8'h00, 8'h01}));
        chk("reload_din", 64'({bus.din_1, bus.din_2}), 64'({exp1[0], exp2[0]}));
        chk("we_pairing", 64'(pair_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
